// File: rtl/i2s_clkgen.sv
// I2S bit-clock and word-select generator. Frames always start and end on a
// frame boundary, and the divider and slot width are relatched only at frame ends.
module i2s_clkgen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           wm_i,
  output logic                 busy_o,
  output logic                 i2s_sck_o,
  output logic                 i2s_ws_o,
  output logic                 sck_rise_o,
  output logic                 sck_fall_o,
  output logic                 frame_start_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [1:0]           r_wm_q;
  logic [5:0]           r_bit_cnt;
  logic                 r_sck;
  logic                 r_ws;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_fs;
  logic                 r_busy;

  logic [5:0]           w_half_bits;
  logic [5:0]           w_last_bit;
  logic                 w_tick;
  logic                 w_frame_end;

  // N = 8*(wm+1) marks the right slot; 2N-1 = 16*wm+15 is the last bit of a frame.
  assign w_half_bits = {1'b0, r_wm_q, 3'b000} + 6'd8;
  assign w_last_bit  = {r_wm_q, 4'hF};
  assign w_tick      = (r_div_cnt == r_div_q);
  assign w_frame_end = w_tick && r_sck && (r_bit_cnt == w_last_bit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_div_q   <= '0;
      r_div_cnt <= '0;
      r_wm_q    <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_fs      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_fs   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_sck     <= 1'b0;
          r_ws      <= 1'b0;
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          if (en_i) begin
            r_state <= RUN;
            r_div_q <= div_i;
            r_wm_q  <= wm_i;
            r_fs    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (r_state == RUN && !en_i) begin
            r_state <= DRAIN;
          end else if (r_state == DRAIN && en_i) begin
            r_state <= RUN;
          end
          if (!w_tick) begin
            r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
          end else begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
            if (!r_sck) begin
              r_rise <= 1'b1;
            end else begin
              r_fall <= 1'b1;
              if (w_frame_end) begin
                r_bit_cnt <= '0;
                r_ws      <= 1'b0;
                // A live run request at the boundary wins over finishing the drain.
                if (r_state == RUN || en_i) begin
                  r_fs    <= 1'b1;
                  r_div_q <= div_i;
                  r_wm_q  <= wm_i;
                end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
                if (r_bit_cnt + 6'd1 == w_half_bits) begin
                  r_ws <= 1'b1;
                end
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign i2s_sck_o     = r_sck;
  assign i2s_ws_o      = r_ws;
  assign sck_rise_o    = r_rise;
  assign sck_fall_o    = r_fall;
  assign frame_start_o = r_fs;

endmodule

// File: doc/i2s_clkgen.md
I2S_CLKGEN -- requirements
Module: i2s_clkgen

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, meaning the width of the SCK half-period divider.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en_i  input  1  run request; 1 = generate frames, 0 = stop at the next frame boundary.
REQ-005 SHALL have port div_i  input  DIV_WIDTH  SCK half-period in clk_i cycles, minus 1.
REQ-006 SHALL have port wm_i  input  2  slot width per channel: 00 = 8, 01 = 16, 10 = 24, 11 = 32 bits.
REQ-007 SHALL have port busy_o  output  1  high in RUN and DRAIN.
REQ-008 SHALL have port i2s_sck_o  output  1  bit clock, fed to i2s_core i2s_sck_i and the pad.
REQ-009 SHALL have port i2s_ws_o  output  1  word select: 0 = left slot, 1 = right slot; fed to i2s_core i2s_ws_i.
REQ-010 SHALL have port sck_rise_o  output  1  one-cycle pulse coincident with the 0->1 transition of i2s_sck_o.
REQ-011 SHALL have port sck_fall_o  output  1  one-cycle pulse coincident with the 1->0 transition of i2s_sck_o.
REQ-012 SHALL have port frame_start_o  output  1  one-cycle pulse marking the start of a left slot.

Function
REQ-013 SHALL drive every output from a register, with no combinational path from any input to any output.
REQ-014 SHALL implement the states IDLE, RUN and DRAIN.
REQ-015 In IDLE, SHALL hold i2s_sck_o = 0, i2s_ws_o = 0, the divider counter at 0 and the bit counter at 0.
REQ-016 On an edge where the state is IDLE and en_i = 1, SHALL:
- go to RUN,
- latch div_i into div_q and wm_i into wm_q,
- set frame_start_o = 1 for one cycle.
REQ-017 SHALL define N = 8*(wm_q+1) and a frame of 2N SCK periods; the bit counter is 6 bits wide, 0..2N-1.
REQ-018 In RUN or DRAIN, SHALL increment the divider counter each cycle. When it equals div_q, it SHALL wrap to 0 and toggle i2s_sck_o, so each SCK half-period is div_q+1 clk_i cycles (div_q = 0 gives clk/2).
REQ-019 On a 0->1 toggle, SHALL assert sck_rise_o in the same cycle as the new i2s_sck_o value.
REQ-020 On a 1->0 toggle, SHALL assert sck_fall_o in the same cycle as the new i2s_sck_o value, and advance the bit counter.
REQ-021 When the bit counter advances to N, SHALL set i2s_ws_o = 1 on the same edge.
REQ-022 When the bit counter wraps from 2N-1 to 0 (the frame end), SHALL on that same edge:
- set i2s_ws_o = 0,
- pulse frame_start_o,
- relatch div_i and wm_i.
REQ-023 Changes to div_i and wm_i outside a latch point SHALL have no effect until the next frame end.
REQ-024 In RUN with en_i = 0, SHALL go to DRAIN and keep generating SCK and WS unchanged.
REQ-025 In DRAIN with en_i = 1, SHALL return to RUN with no gap or glitch on SCK or WS.
REQ-026 At the frame end while in DRAIN, SHALL enter IDLE with i2s_sck_o = 0 and i2s_ws_o = 0; frame_start_o SHALL NOT pulse.
REQ-027 If en_i = 1 at the DRAIN frame end, RUN SHALL take priority, and the frame end SHALL be handled as a normal RUN frame end.
REQ-028 SHALL keep busy_o = 1 from the cycle after RUN is entered through the cycle IDLE is re-entered, exclusive.
REQ-029 SHALL never emit a partial frame except on reset: exactly 2N falling edges per frame.

Reset
REQ-030 While rst_i = 1, SHALL force on the next clk_i edge:
- state to IDLE,
- all counters to 0,
- div_q and wm_q to 0,
- every output to 0.
REQ-031 A reset mid-frame SHALL abort the frame immediately, with no drain.
REQ-032 After rst_i deasserts, the block SHALL restart per REQ-016 on the first edge with en_i = 1.

Verification
REQ-033 div_i = 0, wm_i = 00, en_i held at 1:
- SCK period is 2 clk; first sck_rise_o is 1 clk after RUN entry.
- WS is low for 16 clk and high for 16 clk.
- frame_start_o fires every 32 clk.
- 16 sck_fall_o pulses occur per frame.
REQ-034 div_i = 3, wm_i = 01: SCK is high 4 clk and low 4 clk, WS rises after 16 falls, and a frame is 256 clk.
REQ-035 Config change mid-frame: start with wm_i = 00; change wm_i to 11 and div_i to 1 at bit 5. The current frame SHALL finish as 16 SCK at the old divider, and the next frame SHALL be 64 SCK at a 4 clk period.
REQ-036 Drop en_i at bit 3 of the right slot:
- the frame completes, then IDLE is entered with SCK = 0 and WS = 0;
- busy_o falls on the same edge;
- no further pulses occur.
- A variant re-raises en_i during DRAIN and checks for continuous frames.
REQ-037 Assert rst_i for 1 cycle mid-frame: all outputs are 0 on the next cycle. With en_i = 1, the next cycle re-enters RUN with frame_start_o = 1 and the bit counter at 0.
REQ-038 Checker, run in every scenario:
- sck_rise_o and sck_fall_o each match the i2s_sck_o transitions exactly;
- WS changes only together with sck_fall_o.
